// File: rtl/bcd_cnt_pkg.sv
// ============================================================================
// Module      : bcd_cnt_pkg
// Description : Shared BCD digit type, digit limits and the clamp helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_cnt_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit.sv
// ============================================================================
// Module      : bcd_digit
// Description : One BCD decade with load, step and combinational carry/borrow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit
  import bcd_cnt_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       dir,
  input  logic       load,
  input  bcd_digit_t load_digit,
  output bcd_digit_t digit,
  output logic       carry_out
);

  bcd_digit_t digit_d;
  bcd_digit_t digit_q;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = bcd_clamp(load_digit);
    end else if (step) begin
      if (dir) begin
        digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
      end else begin
        digit_d = (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q <= BCD_MIN;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;
  // Carry (up) or borrow (down): this decade rolls over on the current step.
  assign carry_out = step && (dir ? (digit_q == BCD_MIN) : (digit_q == BCD_MAX));

endmodule

`default_nettype wire

// File: rtl/bcd_counter_n.sv
// ============================================================================
// Module      : bcd_counter_n
// Description : N-decade synchronous BCD counter with load, wrap/saturate and
//               optional down counting (enabled by BCD_CNT_DOWN_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_counter_n
  import bcd_cnt_pkg::*;
#(
  parameter int DIGITS    = 3,
  parameter int WRAP_MODE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
`ifdef BCD_CNT_DOWN_EN
  input  logic                dir,
`endif
  output logic [4*DIGITS-1:0] q,
  output logic                at_limit,
  output logic                wrap,
  output logic                load_err
);

  logic              dir_w;
  logic [DIGITS-1:0] step;
  logic [DIGITS-1:0] carry;
  logic [DIGITS-1:0] at_term;
  logic              wrap_d;
  logic              wrap_q;
  logic              load_err_d;
  logic              load_err_q;

`ifdef BCD_CNT_DOWN_EN
  assign dir_w = dir;
`else
  assign dir_w = 1'b0;
`endif

  assign at_limit = &at_term;

  // Saturating builds block the first step at the terminal value.
  assign step[0] = en && !load && !((WRAP_MODE == 0) && at_limit);

  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      if (k > 0) begin : g_chain
        assign step[k] = carry[k-1];
      end

      bcd_digit u_digit (
        .clk        (clk),
        .rst        (rst),
        .step       (step[k]),
        .dir        (dir_w),
        .load       (load),
        .load_digit (load_val[4*k +: 4]),
        .digit      (q[4*k +: 4]),
        .carry_out  (carry[k])
      );

      assign at_term[k] = dir_w ? (q[4*k +: 4] == BCD_MIN) : (q[4*k +: 4] == BCD_MAX);
    end
  endgenerate

  always_comb begin
    wrap_d     = carry[DIGITS-1];
    load_err_d = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (load_val[4*k +: 4] > BCD_MAX) begin
        load_err_d = load;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_counter_n.sv
// ============================================================================
// Module      : tb_bcd_counter_n
// Description : Random and directed check of bcd_counter_n (wrap and saturate
//               instances) against an integer-valued reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_counter_n;

  localparam int D    = 3;
  localparam int MAXV = 999;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          load;
  logic [4*D-1:0] load_val;
  logic          dir;

  logic [4*D-1:0] q1, q0;
  logic          al1, al0, w1, w0, e1, e0;

  int m1, m0;
  bit wr1, wr0, er;
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  bcd_counter_n #(.DIGITS(D), .WRAP_MODE(1)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
`ifdef BCD_CNT_DOWN_EN
    .dir(dir),
`endif
    .q(q1), .at_limit(al1), .wrap(w1), .load_err(e1)
  );

  bcd_counter_n #(.DIGITS(D), .WRAP_MODE(0)) u_sat (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
`ifdef BCD_CNT_DOWN_EN
    .dir(dir),
`endif
    .q(q0), .at_limit(al0), .wrap(w0), .load_err(e0)
  );

  function automatic bit cur_down();
`ifdef BCD_CNT_DOWN_EN
    return dir;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [4*D-1:0] to_bcd(input int m);
    logic [4*D-1:0] r;
    int v;
    r = '0;
    v = m;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int clamp_val(input logic [4*D-1:0] v);
    int r;
    int p;
    int d;
    r = 0;
    p = 1;
    for (int i = 0; i < D; i++) begin
      d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      r = r + d * p;
      p = p * 10;
    end
    return r;
  endfunction

  function automatic bit any_bad(input logic [4*D-1:0] v);
    bit b;
    b = 1'b0;
    for (int i = 0; i < D; i++) if (v[4*i +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  task automatic model_step(input int wm, inout int m, inout bit w);
    w = 1'b0;
    if (rst) m = 0;
    else if (load) m = clamp_val(load_val);
    else if (en) begin
      if (!cur_down()) begin
        if (m == MAXV) begin
          if (wm != 0) begin m = 0; w = 1'b1; end
        end else m = m + 1;
      end else begin
        if (m == 0) begin
          if (wm != 0) begin m = MAXV; w = 1'b1; end
        end else m = m - 1;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic bit lim(input int m);
    return cur_down() ? (m == 0) : (m == MAXV);
  endfunction

  task automatic compare_all();
    chk("q_wrap",        32'(q1),  32'(to_bcd(m1)));
    chk("at_limit_wrap", 32'(al1), 32'(lim(m1)));
    chk("wrap_wrap",     32'(w1),  32'(wr1));
    chk("load_err_wrap", 32'(e1),  32'(er));
    chk("q_sat",         32'(q0),  32'(to_bcd(m0)));
    chk("at_limit_sat",  32'(al0), 32'(lim(m0)));
    chk("wrap_sat",      32'(w0),  32'(wr0));
    chk("load_err_sat",  32'(e0),  32'(er));
  endtask

  // Inputs are set at the falling edge before calling; outputs checked at the next one.
  task automatic cyc();
    @(posedge clk);
    er = !rst && load && any_bad(load_val);
    model_step(1, m1, wr1);
    model_step(0, m0, wr0);
    @(negedge clk);
    compare_all();
  endtask

  int wrap_cnt, lim_cnt;
  logic [4*D-1:0] q_at_wrap;

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; load_val = '0; dir = 1'b0;
    m1 = 0; m0 = 0; wr1 = 0; wr0 = 0; er = 0;
    @(negedge clk);
    cyc();
    chk("reset_q_lit", 32'(q1), 32'h000);
    chk("reset_at_limit_lit", 32'(al1), 32'h0);

    // Full 1000-step sweep.
    rst = 1'b0; en = 1'b1;
    wrap_cnt = 0; lim_cnt = 0; q_at_wrap = '1;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      if (w1) begin wrap_cnt++; q_at_wrap = q1; end
      if (al1) lim_cnt++;
    end
    chk("sweep_wrap_once_lit", 32'(wrap_cnt), 32'd1);
    chk("sweep_wrap_at_zero_lit", 32'(q_at_wrap), 32'h000);
    chk("sweep_at_limit_once_lit", 32'(lim_cnt), 32'd1);

    // Saturating instance holds at all-nines.
    for (int i = 0; i < 5; i++) cyc();
    chk("sat_hold_q_lit", 32'(q0), 32'h999);
    chk("sat_hold_limit_lit", 32'(al0), 32'h1);
    chk("sat_hold_wrap_lit", 32'(w0), 32'h0);

    // Load with en in the same cycle, then a two-digit carry.
    load = 1'b1; load_val = 12'h599;
    cyc();
    chk("load_599_lit", 32'(q1), 32'h599);
    load = 1'b0;
    cyc();
    chk("carry_600_lit", 32'(q1), 32'h600);

    // Clamped load.
    load = 1'b1; load_val = 12'hA3F; en = 1'b0;
    cyc();
    chk("clamp_939_lit", 32'(q1), 32'h939);
    chk("clamp_err_lit", 32'(e1), 32'h1);
    load = 1'b0;
    cyc();
    chk("clamp_err_pulse_lit", 32'(e1), 32'h0);

    // Reset at 999 with en high suppresses the wrap.
    load = 1'b1; load_val = 12'h999; en = 1'b1;
    cyc();
    load = 1'b0; rst = 1'b1;
    cyc();
    chk("rst_q_lit", 32'(q1), 32'h000);
    chk("rst_wrap_lit", 32'(w1), 32'h0);
    rst = 1'b0;

`ifdef BCD_CNT_DOWN_EN
    dir = 1'b1; en = 1'b0; load = 1'b1; load_val = 12'h100;
    cyc();
    load = 1'b0; en = 1'b1;
    cyc();
    chk("down_099_lit", 32'(q1), 32'h099);
    cyc();
    chk("down_098_lit", 32'(q1), 32'h098);
    load = 1'b1; load_val = 12'h000; en = 1'b0;
    cyc();
    load = 1'b0; en = 1'b1;
    cyc();
    chk("down_wrap_999_lit", 32'(q1), 32'h999);
    chk("down_wrap_pulse_lit", 32'(w1), 32'h1);
    chk("down_sat_000_lit", 32'(q0), 32'h000);
    dir = 1'b0;
`endif

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      load     = ($urandom_range(0, 15) == 0);
      en       = ($urandom_range(0, 3) != 0);
      load_val = 12'($urandom());
      if ($urandom_range(0, 1) == 0) load_val = to_bcd(int'($urandom_range(990, 999)));
      if ($urandom_range(0, 1) == 0) load_val = to_bcd(int'($urandom_range(0, 9)));
`ifdef BCD_CNT_DOWN_EN
      if ($urandom_range(0, 31) == 0) dir = ~dir;
`endif
      cyc();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
